// File: rtl/uart_tx_arbiter_if.sv
// Requester/sender bus of the UART transmit arbiter.
// master: the arbiter. slave: the requesters plus the UART sender.
interface uart_tx_arbiter_if #(
    parameter int unsigned NUM_REQ = 4
);
    logic [NUM_REQ-1:0]   req;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   grant;
    logic [7:0]           tx_data;
    logic                 tx_en;
    logic                 tx_status;
    logic                 busy;
    logic [2:0]           owner;
    logic                 err;

    modport master (
        input  req,
        input  req_data,
        input  tx_status,
        output grant,
        output tx_data,
        output tx_en,
        output busy,
        output owner,
        output err
    );

    modport slave (
        output req,
        output req_data,
        output tx_status,
        input  grant,
        input  tx_data,
        input  tx_en,
        input  busy,
        input  owner,
        input  err
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Shares one UART sender among NUM_REQ requesters: one byte per grant, round robin.
// Sequences the sender's tx_en/tx_status handshake with an optional gap after each
// byte and a watchdog on the sender starting.
// Optional build macro UART_ARB_PRIO0_EN: requester 0 always wins when requesting,
// the others rotate among themselves.
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned GAP_CYCLES   = 0,
    parameter int unsigned BUSY_TIMEOUT = 16
) (
    input  logic               sysclk,
    input  logic               reset,
    uart_tx_arbiter_if.master  bus
);

    localparam int unsigned CNT_W = 16;
    localparam int unsigned OWN_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_BUSY = 2'd1,
        ST_WAIT_DONE = 2'd2,
        ST_GAP       = 2'd3
    } state_t;

    state_t              state_q,   state_d;
    logic [CNT_W-1:0]    cnt_q,     cnt_d;
    logic [NUM_REQ-1:0]  grant_q,   grant_d;
    logic [7:0]          tx_data_q, tx_data_d;
    logic                tx_en_q,   tx_en_d;
    logic                busy_q,    busy_d;
    logic [OWN_W-1:0]    owner_q,   owner_d;
    logic                err_q,     err_d;

    logic                win_valid;
    logic [OWN_W-1:0]    win_idx;
    logic [7:0]          win_data;
    logic [NUM_REQ-1:0]  win_onehot;

    // Winner selection: first request above the last owner, else first at or below it.
    always_comb begin
        win_valid  = 1'b0;
        win_idx    = '0;
        win_data   = '0;
        win_onehot = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (!win_valid && bus.req[i] && (OWN_W'(i) > owner_q)) begin
                win_valid = 1'b1;
                win_idx   = OWN_W'(i);
                win_data  = bus.req_data[8*i +: 8];
            end
        end
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (!win_valid && bus.req[i] && (OWN_W'(i) <= owner_q)) begin
                win_valid = 1'b1;
                win_idx   = OWN_W'(i);
                win_data  = bus.req_data[8*i +: 8];
            end
        end
`ifdef UART_ARB_PRIO0_EN
        // Requester 0 overrides the rotation whenever it asks.
        if (bus.req[0]) begin
            win_valid = 1'b1;
            win_idx   = '0;
            win_data  = bus.req_data[7:0];
        end
`else
        // Pure rotation over all requesters.
`endif
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            win_onehot[i] = win_valid && (win_idx == OWN_W'(i));
        end
    end

    // Next state and next registered outputs; pulses default low every cycle.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        grant_d   = '0;
        tx_en_d   = 1'b0;
        err_d     = 1'b0;
        tx_data_d = tx_data_q;
        owner_d   = owner_q;

        case (state_q)
            ST_IDLE: begin
                // Launch only once the sender reports idle (covers reset mid-frame).
                if (bus.tx_status && win_valid) begin
                    tx_data_d = win_data;
                    tx_en_d   = 1'b1;
                    grant_d   = win_onehot;
                    owner_d   = win_idx;
                    cnt_d     = '0;
                    state_d   = ST_WAIT_BUSY;
                end
            end
            ST_WAIT_BUSY: begin
                // Sender must drop tx_status within BUSY_TIMEOUT cycles or the byte is lost.
                if (!bus.tx_status) begin
                    cnt_d   = '0;
                    state_d = ST_WAIT_DONE;
                end else if (cnt_q + CNT_W'(1) == CNT_W'(BUSY_TIMEOUT)) begin
                    cnt_d   = '0;
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_WAIT_DONE: begin
                if (bus.tx_status) begin
                    cnt_d   = '0;
                    state_d = (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;
                end
            end
            ST_GAP: begin
                if (cnt_q + CNT_W'(1) >= CNT_W'(GAP_CYCLES)) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            grant_q   <= '0;
            tx_data_q <= '0;
            tx_en_q   <= 1'b0;
            busy_q    <= 1'b0;
            owner_q   <= OWN_W'(NUM_REQ - 1);
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            grant_q   <= grant_d;
            tx_data_q <= tx_data_d;
            tx_en_q   <= tx_en_d;
            busy_q    <= busy_d;
            owner_q   <= owner_d;
            err_q     <= err_d;
        end
    end

    assign bus.grant   = grant_q;
    assign bus.tx_data = tx_data_q;
    assign bus.tx_en   = tx_en_q;
    assign bus.busy    = busy_q;
    assign bus.owner   = owner_q;
    assign bus.err     = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomised bench for uart_tx_arbiter against a rule-level reference model,
// plus directed latency/sequence/watchdog/gap/reset scenarios.
module tb_uart_tx_arbiter;

    localparam int N     = 4;
    localparam int GAP   = 5;
    localparam int TO    = 16;
    localparam int FRAME = 20;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.NUM_REQ(N)) bus();

    uart_tx_arbiter #(
        .NUM_REQ      (N),
        .GAP_CYCLES   (GAP),
        .BUSY_TIMEOUT (TO)
    ) dut (
        .sysclk (clk),
        .reset  (reset),
        .bus    (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // environment policy
    logic         rst_req;
    logic [N-1:0] allowed;
    int           p_raise, p_keep, p_drop;
    bit           fixed_en;
    logic [7:0]   fixed_data [N];
    logic [7:0]   rq_data [N];
    bit           stuck;
    int           snd_cnt;
    logic [N-1:0] g_seen;
    logic         prev_status;

    // event logs
    int tx_cyc_q[$];
    int tx_idx_q[$];
    int tx_dat_q[$];
    int err_cyc_q[$];
    int rise_q[$];
    int req0_rise_q[$];

    // reference model: expected outputs plus progress of the current byte
    logic [N-1:0] exp_grant;
    logic         exp_tx_en, exp_busy, exp_err;
    logic [7:0]   exp_tx_data;
    logic [2:0]   exp_owner;
    int           m_owner;
    bit           m_await_start;
    bit           m_sending;
    int           m_age;
    int           m_gap_left;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    function automatic int onehot_idx(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    // Winner = requester at the smallest forward distance from the last owner.
    function automatic int pick(input logic [N-1:0] r, input int last);
        int best  = -1;
        int bestd = N;
`ifdef UART_ARB_PRIO0_EN
        if (r[0]) return 0;
`endif
        for (int i = 0; i < N; i++) begin
            if (r[i]) begin
                int d;
                d = (i - last - 1 + 2 * N) % N;
                if (d < bestd) begin
                    bestd = d;
                    best  = i;
                end
            end
        end
        return best;
    endfunction

    task automatic model_reset();
        exp_grant     = '0;
        exp_tx_en     = 1'b0;
        exp_tx_data   = 8'h00;
        exp_busy      = 1'b0;
        exp_err       = 1'b0;
        m_owner       = N - 1;
        exp_owner     = 3'(m_owner);
        m_await_start = 0;
        m_sending     = 0;
        m_age         = 0;
        m_gap_left    = 0;
    endtask

    // Advance the model by one clock edge using the inputs the DUT is about to sample.
    task automatic model_step();
        logic st;
        st = bus.tx_status;
        if (reset) begin
            model_reset();
            return;
        end
        exp_grant = '0;
        exp_tx_en = 1'b0;
        exp_err   = 1'b0;
        if (m_await_start) begin
            if (!st) begin
                m_await_start = 0;
                m_sending     = 1;
            end else begin
                m_age++;
                if (m_age == TO) begin
                    exp_err       = 1'b1;
                    m_await_start = 0;
                end
            end
        end else if (m_sending) begin
            if (st) begin
                m_sending  = 0;
                m_gap_left = GAP;
            end
        end else if (m_gap_left > 0) begin
            m_gap_left--;
        end else if (st && (bus.req != '0)) begin
            int w;
            w             = pick(bus.req, m_owner);
            m_owner       = w;
            exp_owner     = 3'(w);
            exp_grant     = '0;
            exp_grant[w]  = 1'b1;
            exp_tx_en     = 1'b1;
            exp_tx_data   = bus.req_data[8*w +: 8];
            m_await_start = 1;
            m_age         = 0;
        end
        exp_busy = m_await_start || m_sending || (m_gap_left > 0);
    endtask

    // Inputs for the next cycle: reset, sender status, requesters.
    task automatic drive();
        reset = rst_req;
        if (snd_cnt > 0) begin
            bus.tx_status = 1'b0;
            snd_cnt--;
        end else begin
            bus.tx_status = 1'b1;
        end
        if (bus.tx_status && !prev_status) rise_q.push_back(cyc);
        prev_status = bus.tx_status;
        for (int i = 0; i < N; i++) begin
            int roll;
            roll = int'($urandom_range(0, 99));
            if (!allowed[i]) begin
                bus.req[i] = 1'b0;
            end else if (bus.req[i]) begin
                if (g_seen[i]) begin
                    if (roll < p_keep) begin
                        if (!fixed_en) rq_data[i] = 8'($urandom_range(0, 255));
                    end else begin
                        bus.req[i] = 1'b0;
                    end
                end else if (roll < p_drop) begin
                    bus.req[i] = 1'b0;
                end
            end else if (roll < p_raise) begin
                bus.req[i] = 1'b1;
                rq_data[i] = fixed_en ? fixed_data[i] : 8'($urandom_range(0, 255));
                if (i == 0) req0_rise_q.push_back(cyc);
            end
            bus.req_data[8*i +: 8] = rq_data[i];
        end
    endtask

    // One clock: check at negedge, log, step model and sender, drive after posedge.
    task automatic tick();
        @(negedge clk);
        check_eq("grant",   32'(bus.grant),   32'(exp_grant));
        check_eq("tx_en",   32'(bus.tx_en),   32'(exp_tx_en));
        check_eq("tx_data", 32'(bus.tx_data), 32'(exp_tx_data));
        check_eq("busy",    32'(bus.busy),    32'(exp_busy));
        check_eq("owner",   32'(bus.owner),   32'(exp_owner));
        check_eq("err",     32'(bus.err),     32'(exp_err));
        if (bus.tx_en === 1'b1) begin
            tx_cyc_q.push_back(cyc);
            tx_idx_q.push_back(onehot_idx(bus.grant));
            tx_dat_q.push_back(int'(bus.tx_data));
            if (!stuck) snd_cnt = FRAME;
        end
        if (bus.err === 1'b1) err_cyc_q.push_back(cyc);
        g_seen = bus.grant;
        model_step();
        @(posedge clk);
        cyc++;
        #1;
        drive();
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic clear_logs();
        tx_cyc_q.delete();
        tx_idx_q.delete();
        tx_dat_q.delete();
        err_cyc_q.delete();
        rise_q.delete();
        req0_rise_q.delete();
    endtask

    task automatic do_reset(input int n);
        rst_req = 1'b1;
        ticks(n);
        rst_req = 1'b0;
    endtask

    task automatic set_hold(input logic [N-1:0] mask);
        allowed = mask;
        p_raise = 100;
        p_keep  = 100;
        p_drop  = 0;
    endtask

    task automatic check_seq(input string tag, input int exp_idx [5], input int cnt);
        check_eq({tag, "_launches"}, 32'(tx_cyc_q.size() >= cnt), 32'd1);
        for (int k = 0; k < cnt && k < tx_cyc_q.size(); k++) begin
            check_eq({tag, "_idx"},  32'(tx_idx_q[k]), 32'(exp_idx[k]));
            check_eq({tag, "_data"}, 32'(tx_dat_q[k]), 32'(8'hA0 + exp_idx[k]));
        end
    endtask

    initial begin
        int seq2 [5];
        int seq6 [5];

        rst_req       = 1'b1;
        reset         = 1'b1;
        bus.req       = '0;
        bus.req_data  = '0;
        bus.tx_status = 1'b1;
        prev_status   = 1'b1;
        snd_cnt       = 0;
        stuck         = 0;
        allowed       = '0;
        p_raise       = 0;
        p_keep        = 0;
        p_drop        = 0;
        fixed_en      = 1;
        g_seen        = '0;
        for (int i = 0; i < N; i++) begin
            rq_data[i]    = 8'h00;
            fixed_data[i] = 8'(8'hA0 + i);
        end
        model_reset();
        @(posedge clk);
        #1;

        // reset values held for a few cycles
        ticks(3);
        rst_req = 1'b0;
        ticks(2);

        // single requester, latency and data
        clear_logs();
        fixed_data[0] = 8'h55;
        allowed = 4'b0001; p_raise = 100; p_keep = 0; p_drop = 0;
        ticks(1);
        p_raise = 0;
        ticks(35);
        check_eq("t1_launches", 32'(tx_cyc_q.size()), 32'd1);
        if (tx_cyc_q.size() > 0 && req0_rise_q.size() > 0) begin
            check_eq("t1_latency", 32'(tx_cyc_q[0] - req0_rise_q[0]), 32'd1);
            check_eq("t1_idx",     32'(tx_idx_q[0]), 32'd0);
            check_eq("t1_data",    32'(tx_dat_q[0]), 32'h55);
        end
        fixed_data[0] = 8'hA0;
        allowed = '0;

        // all four held from reset
        do_reset(2);
        clear_logs();
        set_hold(4'b1111);
        ticks(5 * (3 + GAP + FRAME) + 5);
`ifdef UART_ARB_PRIO0_EN
        seq2 = '{0, 0, 0, 0, 0};
`else
        seq2 = '{0, 1, 2, 3, 0};
`endif
        check_seq("t2", seq2, 5);
        allowed = '0;
        ticks(40);

        // requester 0 absent: rotation 1,2,3
        do_reset(2);
        clear_logs();
        set_hold(4'b1110);
        ticks(3 * (3 + GAP + FRAME) + 10);
        seq6 = '{1, 2, 3, 1, 2};
        check_seq("t6", seq6, 3);
        allowed = '0;
        ticks(40);

        // sender never starts: watchdog
        clear_logs();
        stuck = 1;
        allowed = 4'b0010; p_raise = 100; p_keep = 0; p_drop = 0;
        ticks(1);
        p_raise = 0;
        ticks(30);
        check_eq("t3_err_count", 32'(err_cyc_q.size()), 32'd1);
        if (err_cyc_q.size() > 0 && tx_cyc_q.size() > 0)
            check_eq("t3_err_delay", 32'(err_cyc_q[0] - tx_cyc_q[0]), 32'(TO));
        stuck = 0;
        allowed = '0;
        ticks(5);

        // inter-byte gap
        clear_logs();
        set_hold(4'b0100);
        ticks(2 * (3 + GAP + FRAME) + 10);
        check_eq("t4_launches", 32'(tx_cyc_q.size() >= 2), 32'd1);
        if (tx_cyc_q.size() >= 2 && rise_q.size() >= 1) begin
            check_eq("t4_spacing", 32'(tx_cyc_q[1] - tx_cyc_q[0]), 32'(3 + GAP + FRAME));
            check_eq("t4_gap",     32'(tx_cyc_q[1] - rise_q[0]),   32'(GAP + 2));
        end
        allowed = '0;
        ticks(40);

        // reset while the sender is shifting
        clear_logs();
        set_hold(4'b0001);
        ticks(10);
        check_eq("t5_launched", 32'(tx_cyc_q.size()), 32'd1);
        do_reset(1);
        clear_logs();
        ticks(25);
        check_eq("t5_rise", 32'(rise_q.size() >= 1), 32'd1);
        check_eq("t5_relaunch_count", 32'(tx_cyc_q.size() >= 1), 32'd1);
        if (rise_q.size() >= 1 && tx_cyc_q.size() >= 1)
            check_eq("t5_relaunch", 32'(tx_cyc_q[0] - rise_q[0]), 32'd1);
        allowed = '0;
        ticks(40);

        // random traffic, stuck-sender episodes, sporadic resets
        fixed_en = 0;
        allowed = 4'b1111; p_raise = 30; p_keep = 50; p_drop = 5;
        for (int k = 0; k < 2500; k++) begin
            stuck   = (((k / 300) % 4) == 3);
            rst_req = ($urandom_range(0, 499) == 0);
            tick();
        end
        rst_req = 1'b0;
        stuck = 0;
        allowed = '0;
        ticks(40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
